// File: rtl/ssled_scan_pkg.sv
// ============================================================================
// Module : ssled_scan_pkg
// Brief  : Shared scan states, digit/segment widths and a one-hot helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ssled_scan_pkg;

  localparam int N_DIG = 8;
  localparam int SEG_W = 8;
  localparam int DIG_W = $clog2(N_DIG);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } ssled_state_e;

  function automatic logic [N_DIG-1:0] digit_onehot(input logic [DIG_W-1:0] d);
    logic [N_DIG-1:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssled_scan_if.sv
// ============================================================================
// Module : ssled_scan_if
// Brief  : Display-side bundle: enable and digit data in, segment/digit drive out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ssled_scan_if;
  import ssled_scan_pkg::*;

  logic                   en;
  logic [N_DIG*SEG_W-1:0] ssled;
  logic [SEG_W-1:0]       seg;
  logic [N_DIG-1:0]       dig;
  logic                   frame;

  modport master (output en, output ssled, input seg, input dig, input frame);
  modport slave  (input en, input ssled, output seg, output dig, output frame);
endinterface

`default_nettype wire

// File: rtl/ssled_prescaler.sv
// ============================================================================
// Module : ssled_prescaler
// Brief  : Per-digit slot counter; strobes fire the cycle before a slot or
//          the SHOW phase begins. Build macro: SSLED_BLANK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ssled_prescaler #(
  parameter int DIV       = 8,
  parameter int BLANK_CYC = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic run,
  output logic      slot_start,
  output logic      show_start
);

  localparam int c_CW = $clog2(DIV);
`ifdef SSLED_BLANK_EN
  localparam int c_BLANK = BLANK_CYC;
`else
  localparam int c_BLANK = 1;
`endif

  if (DIV < 4) begin : g_chk_div
    $error("ssled_prescaler: DIV must be at least 4");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= DIV) begin : g_chk_blank
    $error("ssled_prescaler: BLANK_CYC must satisfy 1 <= BLANK_CYC < DIV");
  end

  logic [c_CW-1:0] r_cnt;

  // Strobes look one count ahead so the scan FSM registers its outputs on time.
  assign slot_start = run && (r_cnt == c_CW'(DIV - 1));
  assign show_start = run && (r_cnt == c_CW'(c_BLANK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || slot_start) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssled_scan.sv
// ============================================================================
// Module : ssled_scan
// Brief  : Eight-digit multiplexed seven-segment scanner with frame-atomic
//          shadow register. Build macro: SSLED_BLANK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ssled_scan
  import ssled_scan_pkg::*;
#(
  parameter int   CLK_HZ    = 10_000_000,
  parameter int   DIGIT_HZ  = 1000,
  parameter int   BLANK_CYC = 16,
  parameter logic SEG_ON    = 1'b0,
  parameter logic DIG_ON    = 1'b0
) (
  input wire logic     clk,
  input wire logic     rst_n,
  ssled_scan_if.slave  bus
);

  localparam int               c_DIV     = CLK_HZ / DIGIT_HZ;
  localparam logic [1:0]       c_ST_OFF   = ST_OFF;
  localparam logic [1:0]       c_ST_BLANK = ST_BLANK;
  localparam logic [1:0]       c_ST_SHOW  = ST_SHOW;
  localparam logic [SEG_W-1:0] c_SEG_OFF = {SEG_W{~SEG_ON}};
  localparam logic [N_DIG-1:0] c_DIG_OFF = {N_DIG{~DIG_ON}};

  logic [1:0]             r_state;
  logic [DIG_W-1:0]       r_digit;
  logic [N_DIG*SEG_W-1:0] r_shadow;
  logic [SEG_W-1:0]       r_seg;
  logic [N_DIG-1:0]       r_dig;
  logic                   r_frame;

  logic [1:0]             w_state_nxt;
  logic [DIG_W-1:0]       w_digit_nxt;
  logic                   w_frame_nxt;
  logic                   w_cap;
  logic                   w_run;
  logic                   w_slot_start;
  logic                   w_show_start;
  logic [SEG_W-1:0]       w_seg_byte;

  assign w_run = bus.en && (r_state != c_ST_OFF);

  ssled_prescaler #(
    .DIV       (c_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (w_run),
    .slot_start (w_slot_start),
    .show_start (w_show_start)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_frame_nxt = 1'b0;
    w_cap       = 1'b0;
    if (!bus.en) begin
      w_state_nxt = c_ST_OFF;
      w_digit_nxt = '0;
    end else begin
      case (r_state)
        c_ST_OFF: begin
          w_state_nxt = c_ST_BLANK;
          w_digit_nxt = '0;
          w_frame_nxt = 1'b1;
          w_cap       = 1'b1;
        end
        c_ST_BLANK, c_ST_SHOW: begin
          if (w_slot_start) begin
            w_state_nxt = c_ST_BLANK;
            w_digit_nxt = r_digit + 1'b1;
            w_frame_nxt = (r_digit == DIG_W'(N_DIG - 1));
            w_cap       = w_frame_nxt;
          end else if (w_show_start) begin
            w_state_nxt = c_ST_SHOW;
          end
        end
        default: begin
          w_state_nxt = c_ST_OFF;
          w_digit_nxt = '0;
        end
      endcase
    end
  end

  // Shadow only changes on a frame edge, where the next state is BLANK,
  // so reading the pre-edge shadow for SHOW is always the current frame.
  assign w_seg_byte = r_shadow[{w_digit_nxt, 3'b000} +: SEG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_OFF;
      r_digit  <= '0;
      r_shadow <= '0;
      r_seg    <= c_SEG_OFF;
      r_dig    <= c_DIG_OFF;
      r_frame  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_frame <= w_frame_nxt;
      if (w_cap) begin
        r_shadow <= bus.ssled;
      end
      r_seg <= (w_state_nxt == c_ST_SHOW) ? (w_seg_byte ^ c_SEG_OFF) : c_SEG_OFF;
      r_dig <= (w_state_nxt == c_ST_OFF) ? c_DIG_OFF
                                         : (digit_onehot(w_digit_nxt) ^ c_DIG_OFF);
    end
  end

  assign bus.seg   = r_seg;
  assign bus.dig   = r_dig;
  assign bus.frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_ssled_scan.sv
// ============================================================================
// Module : tb_ssled_scan
// Brief  : Directed bench for ssled_scan at DIV=8, BLANK_CYC=2 (SSLED_BLANK_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ssled_scan;

`ifdef SSLED_BLANK_EN
  localparam int c_BLANK = 2;
`else
  localparam int c_BLANK = 1;
`endif
  localparam logic [63:0] c_PAT_A = 64'h0102040810204080;
  localparam logic [63:0] c_ONES  = {64{1'b1}};
  localparam logic [63:0] c_PAT_B = 64'h00000000000000F0;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ssled_scan_if bus ();

  ssled_scan #(
    .CLK_HZ    (80),
    .DIGIT_HZ  (10),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(input logic [63:0] sh, input int d, input int cnt);
    logic [63:0] t;
    t = sh >> (8 * d);
    return (cnt >= c_BLANK) ? ~t[7:0] : 8'hFF;
  endfunction

  function automatic logic [7:0] exp_dig(input int d);
    logic [7:0] t;
    t = 8'h01 << d;
    return ~t;
  endfunction

  // Leaves the bench just after the negedge where EN rises; the next
  // negedge samples the first (FRAME) cycle of digit 0.
  task automatic restart(input logic [63:0] sh);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    bus.ssled = sh;
    bus.en    = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.ssled = c_PAT_A;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.seg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got=%h want=ff", bus.seg); end
    n_cmp++; if (bus.dig !== 8'hFF) begin n_bad++; $display("FAIL reset_dig got=%h want=ff", bus.dig); end
    n_cmp++; if (bus.frame !== 1'b0) begin n_bad++; $display("FAIL reset_frame got=%b want=0", bus.frame); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.dig !== 8'hFF || bus.seg !== 8'hFF || bus.frame !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_release seg=%h dig=%h frame=%b want ff/ff/0", bus.seg, bus.dig, bus.frame);
    end
  endtask

  task automatic test_first_frame;
    restart(c_PAT_A);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.frame !== (c == 0)) begin n_bad++; $display("FAIL ff_frame c=%0d got=%b want=%b", c, bus.frame, c == 0); end
      n_cmp++; if (bus.dig !== exp_dig(c / 8)) begin n_bad++; $display("FAIL ff_dig c=%0d got=%h want=%h", c, bus.dig, exp_dig(c / 8)); end
      n_cmp++; if (bus.seg !== exp_seg(c_PAT_A, c / 8, c % 8)) begin
        n_bad++; $display("FAIL ff_seg c=%0d got=%h want=%h", c, bus.seg, exp_seg(c_PAT_A, c / 8, c % 8));
      end
    end
  endtask

  task automatic test_no_tear;
    logic [63:0] sh;
    restart(c_PAT_A);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      sh = (c < 64) ? c_PAT_A : c_ONES;
      n_cmp++; if (bus.frame !== (c % 64 == 0)) begin n_bad++; $display("FAIL tear_frame c=%0d got=%b", c, bus.frame); end
      n_cmp++; if (bus.dig !== exp_dig((c / 8) % 8)) begin n_bad++; $display("FAIL tear_dig c=%0d got=%h want=%h", c, bus.dig, exp_dig((c / 8) % 8)); end
      n_cmp++; if (bus.seg !== exp_seg(sh, (c / 8) % 8, c % 8)) begin
        n_bad++; $display("FAIL tear_seg c=%0d got=%h want=%h", c, bus.seg, exp_seg(sh, (c / 8) % 8, c % 8));
      end
      if (c == 27) bus.ssled = c_ONES;
    end
  endtask

  task automatic test_en_drop;
    restart(c_PAT_A);
    for (int c = 0; c <= 44; c++) @(negedge clk);
    n_cmp++; if (bus.dig !== exp_dig(5) || bus.seg !== exp_seg(c_PAT_A, 5, 4)) begin
      n_bad++; $display("FAIL drop_pre dig=%h seg=%h want %h/%h", bus.dig, bus.seg, exp_dig(5), exp_seg(c_PAT_A, 5, 4));
    end
    bus.en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.seg !== 8'hFF || bus.dig !== 8'hFF || bus.frame !== 1'b0) begin
        n_bad++; $display("FAIL drop_off k=%0d seg=%h dig=%h frame=%b want ff/ff/0", k, bus.seg, bus.dig, bus.frame);
      end
    end
    bus.ssled = c_PAT_B;
    bus.en    = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.frame !== (c == 0)) begin n_bad++; $display("FAIL rise_frame c=%0d got=%b want=%b", c, bus.frame, c == 0); end
      n_cmp++; if (bus.dig !== exp_dig(c / 8)) begin n_bad++; $display("FAIL rise_dig c=%0d got=%h want=%h", c, bus.dig, exp_dig(c / 8)); end
      n_cmp++; if (bus.seg !== exp_seg(c_PAT_B, c / 8, c % 8)) begin
        n_bad++; $display("FAIL rise_seg c=%0d got=%h want=%h", c, bus.seg, exp_seg(c_PAT_B, c / 8, c % 8));
      end
    end
  endtask

  task automatic test_async_reset;
    restart(c_PAT_A);
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.seg !== 8'h7F) begin n_bad++; $display("FAIL ar_pre_seg got=%h want=7f", bus.seg); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.seg !== 8'hFF || bus.dig !== 8'hFF || bus.frame !== 1'b0) begin
      n_bad++; $display("FAIL ar_immediate seg=%h dig=%h frame=%b want ff/ff/0", bus.seg, bus.dig, bus.frame);
    end
    @(negedge clk);
    n_cmp++; if (bus.seg !== 8'hFF || bus.dig !== 8'hFF || bus.frame !== 1'b0) begin
      n_bad++; $display("FAIL ar_held_en seg=%h dig=%h frame=%b want ff/ff/0", bus.seg, bus.dig, bus.frame);
    end
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.seg !== 8'hFF || bus.dig !== 8'hFF || bus.frame !== 1'b0) begin
        n_bad++; $display("FAIL ar_idle k=%0d seg=%h dig=%h frame=%b", k, bus.seg, bus.dig, bus.frame);
      end
    end
    bus.en = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.frame !== 1'b1 || bus.dig !== 8'hFE || bus.seg !== 8'hFF) begin
      n_bad++; $display("FAIL ar_restart frame=%b dig=%h seg=%h want 1/fe/ff", bus.frame, bus.dig, bus.seg);
    end
  endtask

  task automatic test_frames;
    int unlit;
    int c;
    restart(c_ONES);
    for (int s = 0; s < 24; s++) begin
      unlit = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        c = s * 8 + k;
        n_cmp++; if (bus.frame !== (c % 64 == 0)) begin n_bad++; $display("FAIL fr_frame c=%0d got=%b", c, bus.frame); end
        n_cmp++; if ($countones(~bus.dig) != 1) begin n_bad++; $display("FAIL fr_onehot c=%0d dig=%h", c, bus.dig); end
        if (bus.seg === 8'hFF) unlit++;
        else if (bus.seg !== 8'h00) begin
          n_cmp++; n_bad++; $display("FAIL fr_seg c=%0d got=%h want=00", c, bus.seg);
        end
      end
      n_cmp++; if (unlit != c_BLANK) begin n_bad++; $display("FAIL fr_unlit slot=%0d got=%0d want=%0d", s, unlit, c_BLANK); end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.ssled = '0;
    test_reset();
    test_first_frame();
    test_no_tear();
    test_en_drop();
    test_async_reset();
    test_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
